vga_sync: RTL

- Free-running VGA timing generator: horizontal/vertical counters produce pixel coordinates, the visible-area flag, sync pulses and frame/line markers.
- Sits directly upstream of the delay stage. Its hsync/vsync/visible outputs feed delay instances so they align with the pixel data pipeline.
- One pixel position per enabled clock.

---
 rtl/vga_sync.sv | 100 ++++++++++
 1 files changed

// File: rtl/vga_sync.sv
// vga_sync: free-running VGA timing generator.
// Counts column/row and decodes visible, sync and line/frame markers.
module vga_sync #(
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter bit H_SYNC_POL    = 1'b0,
    parameter bit V_SYNC_POL    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [9:0] column,
    output logic [9:0] row,
    output logic       visible,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT_PORCH
                           + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT_PORCH
                           + V_SYNC_PULSE + V_BACK_PORCH;

    // 11-bit constants so a sync window ending at 1024 still compares correctly
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SS   = 11'(H_VISIBLE + H_FRONT_PORCH);
    localparam logic [10:0] H_SE   = 11'(H_VISIBLE + H_FRONT_PORCH
                                       + H_SYNC_PULSE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SS   = 11'(V_VISIBLE + V_FRONT_PORCH);
    localparam logic [10:0] V_SE   = 11'(V_VISIBLE + V_FRONT_PORCH
                                       + V_SYNC_PULSE);
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || H_TOTAL < 1) begin : g_h_total_bad
        $error("vga_sync: H_TOTAL does not fit in 10 bits");
    end
    if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_v_total_bad
        $error("vga_sync: V_TOTAL does not fit in 10 bits");
    end

    logic [9:0]  r_col;
    logic [9:0]  r_row;
    logic [10:0] w_col;
    logic [10:0] w_row;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_h_vis;
    logic        w_v_vis;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_col0;

    assign w_col    = {1'b0, r_col};
    assign w_row    = {1'b0, r_row};
    assign w_h_last = (r_col == H_LAST);
    assign w_v_last = (r_row == V_LAST);

    // Advance the pixel position; row steps on column wrap, reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (enable) begin
            if (w_h_last) begin
                r_col <= '0;
                r_row <= w_v_last ? '0 : r_row + 10'd1;
            end else begin
                r_col <= r_col + 10'd1;
            end
        end
    end

    // Zero-latency decode of the counters; reset forces idle outputs.
    always_comb begin
        w_h_vis = (w_col < H_VIS);
        w_v_vis = (w_row < V_VIS);
        w_h_act = (w_col >= H_SS) && (w_col < H_SE);
        w_v_act = (w_row >= V_SS) && (w_row < V_SE);
        w_col0  = (r_col == 10'd0);

        column      = r_col;
        row         = r_row;
        visible     = !reset && w_h_vis && w_v_vis;
        hsync       = (!reset && w_h_act) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync       = (!reset && w_v_act) ? V_SYNC_POL : ~V_SYNC_POL;
        line_start  = !reset && enable && w_col0;
        frame_start = !reset && enable && w_col0 && (r_row == 10'd0);
    end

endmodule
